// File: rtl/result_uart_pkg.sv
// result_uart_pkg: shared FSM state type and packet constants for the result UART.
package result_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] PREAMBLE = 8'hA5;
  localparam int N_WORDS = 16;
  localparam int N_BYTES = 33;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; ready on the last stop-bit cycle so bytes go back-to-back.
module uart_tx_byte
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  state_t state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, sh_n;
  logic tx_n, tick;
  assign tick = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign ready = state == IDLE || (state == STOP && tick);
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
    bit_n = bit_idx;
    sh_n = shreg;
    tx_n = tx;
    case (state)
      IDLE: if (valid) begin
        state_n = START;
        sh_n = data;
        tx_n = 1'b0;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n = '0;
        tx_n = shreg[0];
      end
      DATA: if (tick) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          bit_n = '0;
          tx_n = 1'b1;
        end else begin
          bit_n = bit_idx + 3'd1;
          sh_n = {1'b0, shreg[7:1]};
          tx_n = shreg[1];
        end
      end
      default: if (tick) begin
        state_n = valid ? START : IDLE;
        sh_n = valid ? data : shreg;
        tx_n = !valid;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_idx <= bit_n;
      shreg <= sh_n;
      tx <= tx_n;
    end
  end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: snapshots 16 result words on end_process rise and sends them as a 33-byte UART packet.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              end_process,
  input  logic [WORD_W-1:0] r1,
  input  logic [WORD_W-1:0] r2,
  input  logic [WORD_W-1:0] r3,
  input  logic [WORD_W-1:0] r4,
  input  logic [WORD_W-1:0] r5,
  input  logic [WORD_W-1:0] r6,
  input  logic [WORD_W-1:0] r7,
  input  logic [WORD_W-1:0] r8,
  input  logic [WORD_W-1:0] r9,
  input  logic [WORD_W-1:0] r10,
  input  logic [WORD_W-1:0] r11,
  input  logic [WORD_W-1:0] r12,
  input  logic [WORD_W-1:0] r13,
  input  logic [WORD_W-1:0] r14,
  input  logic [WORD_W-1:0] r15,
  input  logic [WORD_W-1:0] r16,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  logic [WORD_W-1:0] r_arr [N_WORDS];
  logic [WORD_W-1:0] snap [N_WORDS];
  logic [5:0] byte_idx;
  logic [3:0] widx;
  logic [15:0] wide;
  logic [7:0] byte_data;
  logic ep_d, start, byte_valid, ready;
  assign r_arr = '{r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15, r16};
  assign start = end_process && !ep_d && !busy;
  assign byte_valid = busy ? byte_idx < 6'(N_BYTES) : start;
  // byte 0 is the preamble; odd indices carry a word's high byte, even its low byte
  always_comb begin
    widx = 4'((byte_idx - 6'd1) >> 1);
    wide = 16'(snap[widx]);
    byte_data = byte_idx == 6'd0 ? PREAMBLE : byte_idx[0] ? wide[15:8] : wide[7:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ep_d <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      byte_idx <= '0;
      snap <= '{default: '0};
    end else begin
      ep_d <= end_process;
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        byte_idx <= 6'd1;
        snap <= r_arr;
      end else if (busy && ready) begin
        if (byte_idx == 6'(N_BYTES)) begin
          busy <= 1'b0;
          done <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 6'd1;
        end
      end
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (byte_data),
    .valid (byte_valid),
    .ready (ready),
    .tx    (tx)
  );
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Downstream readout stage for the single-core matrix processor. It watches the core's `end_process` flag and snapshots the sixteen 12-bit result words that data memory exposes as `r1`..`r16`. It then streams them off-chip as one framed 8N1 UART packet. It sits beside the data memory at the top level and is the only path for results to leave the FPGA.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `WORD_W`, 12: width of each result word. Must be ≤ 16.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `end_process`  in  1  level flag from the core, high once the program has finished.
- `r1`..`r16`  in  WORD_W each  result words from data memory.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a packet is being transmitted.
- `done`  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- Trigger: rising edge of `end_process`, detected as `end_process && !ep_d`.
  - `ep_d` is a registered copy of `end_process` and resets to 0. A flag that is already high when reset releases therefore triggers one transmission.
- Triggers that arrive while `busy` is high are ignored, not queued.
- On a trigger, all 16 words are captured into a snapshot register in the same cycle. Later changes on `r1`..`r16` do not affect the packet in flight.
- Packet: 33 bytes, sent in this order:
  - preamble 8'hA5;
  - then for k = 1..16, high byte `{(16-WORD_W) zeros, r_k[WORD_W-1:8]}` followed by low byte `r_k[7:0]`.
- Byte framing: 8N1. Start bit 0, data bits LSB first, one stop bit 1.
  - No idle gap between bytes: the next start bit immediately follows the previous stop bit.
- FSM states:
  - IDLE → START on trigger.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if more bytes remain.
  - STOP → IDLE after byte 32; `done` is asserted on this transition.
- Counters:
  - baud counter 0..CLKS_PER_BIT-1, wraps at each bit boundary;
  - bit index 0..7;
  - byte index 0..32, cleared in IDLE.
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0, snapshot 0.
- Reset mid-transfer aborts the packet. `tx` returns to 1 on the next edge, no `done` is pulsed, and nothing is resumed.

## Timing
- Trigger sampled at cycle T. Then `busy`=1 and `tx`=0 (start bit) from cycle T+1.
- Each bit holds `tx` for exactly CLKS_PER_BIT cycles. One byte takes 10·CLKS_PER_BIT cycles.
- The last stop bit ends at cycle T+330·CLKS_PER_BIT.
- At cycle T+1+330·CLKS_PER_BIT: `done`=1 for that one cycle, `busy` falls to 0 in the same cycle, and `tx`=1.
- The earliest accepted retrigger is a fresh rising edge sampled in the cycle `busy` falls or later.
- `tx` is driven directly from a register, so the serial output has no combinational glitches.

## Structure
- Package `result_uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - `PREAMBLE` = 8'hA5;
  - `N_WORDS` = 16;
  - `N_BYTES` = 33.
- Sub-module `uart_tx_byte` is the natural split: a byte serializer with `data`/`valid`/`ready` that owns the baud counter, bit counter and `tx`.
- The top block owns edge detection, the snapshot, byte sequencing, and `busy`/`done`.

## Test plan
All scenarios use CLKS_PER_BIT=4 (frame = 40 cycles, packet = 1320 cycles).
- Reset held 3 cycles → `tx`=1, `busy`=0, `done`=0 throughout and after release with `end_process`=0.
- r1=12'hABC, others 0; `end_process` rises at T:
  - `tx` low at T+1;
  - decoded bytes are A5, 0A, BC, then 30 × 00;
  - `done` pulses at T+1321 and `busy` falls at T+1321.
- All words 12'hFFF → every word pair decodes as 0F, FF. Bit order is checked LSB first on the line (FF → eight 1 bits; 0F → 1,1,1,1,0,0,0,0).
- Snapshot and retrigger:
  - r1 changed to 12'h123 at T+200 → packet still carries 0A, BC;
  - a second `end_process` rise at T+500 is ignored;
  - `end_process` held high past `done` → no retransmission;
  - dropping and re-raising `end_process` → a new packet starting with A5.
- `rst_n` low at T+100 (mid-byte) → `tx`=1 and `busy`=0 on the next edge, and no `done`. A later rising edge produces a full 33-byte packet starting with A5.
